key_mode_ctrl: RTL and testbench
================================

# key_mode_ctrl

Front-panel key controller for the audio path. It takes debounced key events from up to four debounce units (per-key `key_flag` pulse plus `key_state` level). It grants one key at a time, classifies each press as short or long, and sequences the effect-mode, bypass and gain-step registers that configure the audio processing datapath. It sits between the debounce units and the effect/codec configuration logic.

## Interface
- `NUM_KEYS`, default 4: number of debounced keys. Index 0 has the highest priority.
- `LONG_CYCLES`, default 50_000_000: press duration that counts as a long press (1 s at 50 MHz). Must be at least 2.
- `NUM_MODES`, default 5: number of effect modes. Mode values run from 0 to NUM_MODES-1.
- `MODE_W`, default 3: width of the mode register. Must satisfy 2^MODE_W ≥ NUM_MODES.
- `GAIN_MAX`, default 7: highest gain step.
- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high reset.
- `key_flag`, in, NUM_KEYS: one-cycle debounced event pulse per key.
- `key_state`, in, NUM_KEYS: debounced level per key; 0 = pressed. Valid whenever the matching `key_flag` is high.
- `evt_valid`, out, 1: one-cycle pulse marking a classified press.
- `evt_key`, out, 2: index of the key that produced the event.
- `evt_long`, out, 1: 1 = long press, 0 = short press. Valid with `evt_valid`.
- `mode`, out, MODE_W: current effect mode.
- `bypass`, out, 1: audio-effect bypass enable.
- `gain`, out, 3: output gain step.
- `cfg_update`, out, 1: one-cycle pulse, high in the cycle after `mode`, `bypass` or `gain` changes value.
- `busy`, out, 1: high while a key is granted (any state other than IDLE).

## Operation
- Press event = `key_flag[i] & ~key_state[i]`. Release event = `key_flag[i] & key_state[i]`.
- State machine has three states: IDLE, HELD, LONG_HELD.
- IDLE:
  - The lowest-index press event wins the grant. The winning index is latched as `owner` and the hold counter is cleared.
  - Next state is HELD.
  - Release events in IDLE are ignored.
- HELD:
  - The hold counter increments every cycle.
  - If the owner releases, emit a short event and go to IDLE.
  - Otherwise, when the counter reaches LONG_CYCLES-1, emit a long event and go to LONG_HELD.
  - If the owner release and the threshold fall in the same cycle, release wins and the press is short.
- LONG_HELD: the owner release returns the FSM to IDLE with no event.
- Events from non-owner keys are ignored in HELD and LONG_HELD. A non-owner press is never queued.
- Actions on each event:
  - Key 0, short: `mode` increments; NUM_MODES-1 wraps to 0.
  - Key 1, short: `mode` decrements; 0 wraps to NUM_MODES-1.
  - Key 0 or key 1, long: `mode` is set to 0.
  - Key 2, short: `bypass` toggles.
  - Key 2, long: `bypass` is set to 0.
  - Key 3, short: `gain` increments, saturating at GAIN_MAX.
  - Key 3, long: `gain` is set to 0.
  - Keys with index 4 or above, when NUM_KEYS > 4, produce events but no action.
- `cfg_update` fires only when the new value differs from the old one. For example, a long press on key 0 while `mode` is already 0 gives no `cfg_update`.
- The hold counter is ceil(log2(LONG_CYCLES)) bits wide. It never wraps, because it is only compared while in HELD.

## Timing
- Reset values: state IDLE; `evt_valid`, `evt_key`, `evt_long` all 0; `mode` 0; `bypass` 0; `gain` 0; `cfg_update` 0; `busy` 0.
- Press on cycle t: `busy` goes high at t+1 and the hold counter is 0 at t+1.
- A decision (release, or threshold reached) on cycle d gives `evt_valid` at d+1. The config registers take their new value on the same edge, so they are also new at d+1.
- `cfg_update` is high at d+2.
- A long press is reported when the counter reaches LONG_CYCLES-1, i.e. at press+LONG_CYCLES+1, while the key is still held.
- After a release, `busy` drops at d+1. A new press accepted on that same cycle d+1 is granted.
- Reset mid-press returns everything to reset values immediately. A release that arrives after reset is ignored.

## Structure
- Package `key_mode_pkg` holds:
  - the state encoding (one-hot, 3 bits),
  - key index constants KEY_NEXT=0, KEY_PREV=1, KEY_BYP=2, KEY_GAIN=3,
  - the default LONG_CYCLES value.
- One sub-module, `press_timer`: a clear/enable counter with a registered threshold-hit flag, parameterized by LONG_CYCLES.

## Test plan
All scenarios use LONG_CYCLES=100 and NUM_MODES=5.
- Key 0: press, release after 20 cycles, repeated five times. Expect `mode` to step 1, 2, 3, 4, 0, with five `evt_valid` pulses, each having `evt_long`=0, and five `cfg_update` pulses.
- Key 1: press and release after 10 cycles starting from `mode`=0. Expect `mode`=4 and `evt_key`=1.
- Key 3 held for 150 cycles with `gain`=5. Expect `evt_long`=1 at press+101, `gain`=0, and no event on release.
- Key 2 and key 0 pressed in the same cycle. Expect key 0 granted. Key 2's release produces no event, and `bypass` stays 0.
- Key 0 release coinciding with the threshold cycle. Expect a short event and `mode`+1.
- Reset asserted 50 cycles into a key 3 press, then key 3 released. Expect all outputs at 0 and no `evt_valid`.

Source files
------------

// File: rtl/key_mode_pkg.sv
// Shared types and constants for the front-panel key controller.
// Holds the one-hot FSM encoding, key roles and default long-press time.
package key_mode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_HELD      = 3'b010,
    ST_LONG_HELD = 3'b100
  } state_e;

  localparam int KEY_NEXT = 0;
  localparam int KEY_PREV = 1;
  localparam int KEY_BYP  = 2;
  localparam int KEY_GAIN = 3;

  localparam int LONG_CYCLES_DEF = 50_000_000;

endpackage

// File: rtl/press_timer.sv
// Hold-time counter with a registered threshold flag.
// Ports: clk_i, rst_i (async high), clr_i, en_i, hit_o (count == LONG_CYCLES-1).
module press_timer
  import key_mode_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int CW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] PRE_HIT = CW'(LONG_CYCLES - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_q, hit_d;

  // The flag is raised one step early so it is high exactly
  // in the cycle the count sits at LONG_CYCLES-1.
  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
      hit_d = (cnt_q == PRE_HIT);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Grants one debounced key at a time, classifies short/long presses
// and sequences mode/bypass/gain. Ports: clk, reset, key_flag,
// key_state in; evt_*, mode, bypass, gain, cfg_update, busy out.
module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF,
  parameter int NUM_MODES   = 5,
  parameter int MODE_W      = 3,
  parameter int GAIN_MAX    = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  output logic [1:0]          evt_key,
  output logic                evt_long,
  output logic [MODE_W-1:0]   mode,
  output logic                bypass,
  output logic [2:0]          gain,
  output logic                cfg_update,
  output logic                busy
);

  localparam int OW =
    (NUM_KEYS > 4) ? $clog2(NUM_KEYS) : 2;
  localparam logic [MODE_W-1:0] MODE_LAST =
    MODE_W'(NUM_MODES - 1);
  localparam logic [2:0] G_MAX = 3'(GAIN_MAX);
  localparam logic [OW-1:0] K_NEXT = OW'(KEY_NEXT);
  localparam logic [OW-1:0] K_PREV = OW'(KEY_PREV);
  localparam logic [OW-1:0] K_BYP  = OW'(KEY_BYP);
  localparam logic [OW-1:0] K_GAIN = OW'(KEY_GAIN);

  state_e state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] grant_idx;
  logic [NUM_KEYS-1:0] press;
  logic own_rel;
  logic hit;
  logic tmr_clr, tmr_en;
  logic fire, fire_long;

  logic              evt_valid_q;
  logic [1:0]        evt_key_q;
  logic              evt_long_q;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              byp_q, byp_d;
  logic [2:0]        gain_q, gain_d;
  logic              chg_q, cfg_q;

  assign press   = key_flag & ~key_state;
  assign own_rel = key_flag[owner_q]
                 & key_state[owner_q];

  // Scan high to low so the lowest index wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) grant_idx = OW'(i);
    end
  end

  press_timer #(
    .LONG_CYCLES(LONG_CYCLES)
  ) u_timer (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .hit_o (hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|press) begin
          state_d = ST_HELD;
          owner_d = grant_idx;
        end
      end
      ST_HELD: begin
        if (own_rel)  state_d = ST_IDLE;
        else if (hit) state_d = ST_LONG_HELD;
      end
      ST_LONG_HELD: begin
        if (own_rel) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Release is checked first so a release on the
  // threshold cycle still counts as a short press.
  always_comb begin
    tmr_clr   = (state_q == ST_IDLE);
    tmr_en    = (state_q == ST_HELD);
    fire      = 1'b0;
    fire_long = 1'b0;
    if (state_q == ST_HELD) begin
      if (own_rel) begin
        fire = 1'b1;
      end else if (hit) begin
        fire      = 1'b1;
        fire_long = 1'b1;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    byp_d  = byp_q;
    gain_d = gain_q;
    if (fire) begin
      unique case (1'b1)
        owner_q == K_NEXT:
          mode_d = (fire_long || mode_q == MODE_LAST)
                 ? '0 : mode_q + MODE_W'(1);
        owner_q == K_PREV:
          mode_d = fire_long ? '0
                 : (mode_q == '0) ? MODE_LAST
                 : mode_q - MODE_W'(1);
        owner_q == K_BYP:
          byp_d = fire_long ? 1'b0 : ~byp_q;
        owner_q == K_GAIN:
          gain_d = fire_long ? 3'd0
                 : (gain_q == G_MAX) ? gain_q
                 : gain_q + 3'd1;
        default: ;
      endcase
    end
  end

  // chg_q marks the cycle the new value shows;
  // cfg_q delays that by one for the update pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_long_q  <= 1'b0;
      mode_q      <= '0;
      byp_q       <= 1'b0;
      gain_q      <= '0;
      chg_q       <= 1'b0;
      cfg_q       <= 1'b0;
    end else begin
      evt_valid_q <= fire;
      evt_long_q  <= fire_long;
      if (fire) evt_key_q <= 2'(owner_q);
      mode_q <= mode_d;
      byp_q  <= byp_d;
      gain_q <= gain_d;
      chg_q  <= (mode_d != mode_q)
              | (byp_d != byp_q)
              | (gain_d != gain_q);
      cfg_q  <= chg_q;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_key    = evt_key_q;
  assign evt_long   = evt_long_q;
  assign mode       = mode_q;
  assign bypass     = byp_q;
  assign gain       = gain_q;
  assign cfg_update = cfg_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed and randomized bench for key_mode_ctrl.
// Expected behaviour comes from an arithmetic model of the press rules.
module tb_key_mode_ctrl;

  localparam int NK = 4;
  localparam int L  = 100;
  localparam int NM = 5;
  localparam int MW = 3;
  localparam int GM = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_flag;
  logic [NK-1:0] key_state;
  logic          evt_valid;
  logic [1:0]    evt_key;
  logic          evt_long;
  logic [MW-1:0] mode;
  logic          bypass;
  logic [2:0]    gain;
  logic          cfg_update;
  logic          busy;

  always #5 clk = ~clk;

  key_mode_ctrl #(
    .NUM_KEYS(NK), .LONG_CYCLES(L),
    .NUM_MODES(NM), .MODE_W(MW), .GAIN_MAX(GM)
  ) dut (
    .clk(clk), .reset(reset),
    .key_flag(key_flag), .key_state(key_state),
    .evt_valid(evt_valid), .evt_key(evt_key),
    .evt_long(evt_long), .mode(mode),
    .bypass(bypass), .gain(gain),
    .cfg_update(cfg_update), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int ev_cyc[$];
  int ev_key[$];
  bit ev_long[$];
  int cu_cyc[$];
  int m_mode, m_byp, m_gain;
  logic [NK-1:0] lvl;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (evt_valid) begin
      ev_cyc.push_back(cyc_n);
      ev_key.push_back(int'(evt_key));
      ev_long.push_back(evt_long);
    end
    if (cfg_update) cu_cyc.push_back(cyc_n);
  endtask

  task automatic clr_q();
    ev_cyc.delete();
    ev_key.delete();
    ev_long.delete();
    cu_cyc.delete();
  endtask

  function automatic bit model_apply(int k, bit lng);
    int om = m_mode;
    int ob = m_byp;
    int og = m_gain;
    case (k)
      0: m_mode = lng ? 0 : (m_mode + 1) % NM;
      1: m_mode = lng ? 0 : (m_mode + NM - 1) % NM;
      2: m_byp  = lng ? 0 : 1 - m_byp;
      3: m_gain = lng ? 0
                : (m_gain < GM ? m_gain + 1 : GM);
      default: ;
    endcase
    return (om != m_mode) || (ob != m_byp)
        || (og != m_gain);
  endfunction

  task automatic chk_cfg(string tag);
    chk({tag, "_mode"}, mode, m_mode);
    chk({tag, "_byp"}, bypass, m_byp);
    chk({tag, "_gain"}, gain, m_gain);
  endtask

  // Press key k in cycle t, release it in cycle t+h.
  task automatic do_press(int k, int h, bit noise);
    int t, et;
    bit lng, ch;
    t = cyc_n;
    lvl[k] = 1'b0;
    key_flag = '0;
    key_flag[k] = 1'b1;
    key_state = lvl;
    cyc();
    key_flag = '0;
    chk("busy_on", busy, 1);
    for (int j = 1; j < h; j++) begin
      if (noise && $urandom_range(0, 7) == 0) begin
        int n;
        n = $urandom_range(0, NK - 1);
        if (n != k) begin
          lvl[n] = ~lvl[n];
          key_flag[n] = 1'b1;
          key_state = lvl;
        end
      end
      cyc();
      key_flag = '0;
    end
    lvl[k] = 1'b1;
    key_flag[k] = 1'b1;
    key_state = lvl;
    cyc();
    key_flag = '0;
    cyc();
    cyc();
    lvl = '1;
    key_state = lvl;
    lng = (h > L);
    et  = t + (lng ? L : h) + 1;
    ch  = model_apply(k, lng);
    chk("ev_count", ev_cyc.size(), 1);
    if (ev_cyc.size() > 0) begin
      chk("ev_cycle", ev_cyc[0], et);
      chk("ev_key", ev_key[0], k);
      chk("ev_long", ev_long[0], lng);
    end
    chk("cfg_count", cu_cyc.size(), 32'(ch));
    if (ch && cu_cyc.size() > 0)
      chk("cfg_cycle", cu_cyc[0], et + 1);
    chk_cfg("press");
    chk("busy_off", busy, 0);
    clr_q();
  endtask

  initial begin
    reset = 1'b1;
    lvl = '1;
    key_flag = '0;
    key_state = lvl;
    m_mode = 0;
    m_byp = 0;
    m_gain = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();
    chk("rst_evt", {evt_valid, evt_key, evt_long}, 0);
    chk("rst_cfg", cfg_update, 0);
    chk("rst_busy", busy, 0);
    chk_cfg("rst");

    // key 0 stepping mode with wrap
    for (int i = 0; i < 5; i++) do_press(0, 20, 0);
    chk("mode_wrap0", mode, 0);

    // key 1 wrapping down from 0
    do_press(1, 10, 0);
    chk("mode_prev4", mode, 4);

    // release exactly on the threshold cycle
    do_press(0, L, 0);

    // gain up to 5, then long press clears it
    for (int i = 0; i < 5; i++) do_press(3, 5, 0);
    chk("gain5", gain, 5);
    do_press(3, 150, 0);
    chk("gain_long0", gain, 0);

    // simultaneous key 2 and key 0 press
    lvl[0] = 1'b0;
    lvl[2] = 1'b0;
    key_flag = 4'b0101;
    key_state = lvl;
    cyc();
    key_flag = '0;
    repeat (5) cyc();
    lvl[2] = 1'b1;
    key_flag[2] = 1'b1;
    key_state = lvl;
    cyc();
    key_flag = '0;
    repeat (3) cyc();
    chk("sim_k2_noev", ev_cyc.size(), 0);
    chk("sim_byp", bypass, 0);
    chk("sim_busy", busy, 1);
    lvl[0] = 1'b1;
    key_flag[0] = 1'b1;
    key_state = lvl;
    cyc();
    key_flag = '0;
    cyc();
    cyc();
    chk("sim_ev_count", ev_cyc.size(), 1);
    if (ev_cyc.size() > 0) begin
      chk("sim_ev_key", ev_key[0], 0);
      chk("sim_ev_long", ev_long[0], 0);
    end
    void'(model_apply(0, 0));
    chk_cfg("sim");
    clr_q();

    // reset in the middle of a key 3 press
    do_press(3, 5, 0);
    do_press(3, 5, 0);
    lvl[3] = 1'b0;
    key_flag[3] = 1'b1;
    key_state = lvl;
    cyc();
    key_flag = '0;
    repeat (49) cyc();
    reset = 1'b1;
    #1;
    m_mode = 0;
    m_byp = 0;
    m_gain = 0;
    chk("mid_rst_evt",
        {evt_valid, evt_key, evt_long}, 0);
    chk("mid_rst_busy", {cfg_update, busy}, 0);
    chk_cfg("mid_rst");
    cyc();
    reset = 1'b0;
    lvl[3] = 1'b1;
    key_flag[3] = 1'b1;
    key_state = lvl;
    cyc();
    key_flag = '0;
    repeat (4) cyc();
    chk("post_rst_noev", ev_cyc.size(), 0);
    chk("post_rst_busy", busy, 0);
    chk_cfg("post_rst");
    clr_q();

    // randomized presses with non-owner noise
    for (int i = 0; i < 30; i++) begin
      int k, h;
      k = $urandom_range(0, NK - 1);
      h = ($urandom_range(0, 3) == 0)
        ? $urandom_range(L - 3, L + 3)
        : $urandom_range(1, 60);
      do_press(k, h, 1);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
